// File: rtl/fpu_lane_sequencer.sv
// Splits one NUM_LANES-wide FP request into FPU_LANES-wide packets for a narrower core,
// then reassembles the packet responses into a single tagged response.
module fpu_lane_sequencer #(
    parameter int  NUM_LANES = 4,
    parameter int  FPU_LANES = 1,
    parameter int  TAGW      = 4,
    parameter int  DATAW     = 32,
    localparam int NUM_PKTS  = NUM_LANES / FPU_LANES,
    localparam int PIDW      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [NUM_LANES-1:0]          lane_mask,
    input  logic [TAGW-1:0]               tag_in,
    input  logic [3:0]                    op_type,
    input  logic [1:0]                    fmt,
    input  logic [2:0]                    frm,
    input  logic [NUM_LANES*DATAW-1:0]    dataa,
    input  logic [NUM_LANES*DATAW-1:0]    datab,
    input  logic [NUM_LANES*DATAW-1:0]    datac,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [NUM_LANES*DATAW-1:0]    result,
    output logic                          has_fflags,
    output logic [4:0]                    fflags,
    output logic [TAGW-1:0]               tag_out,
    output logic                          fpu_valid,
    input  logic                          fpu_ready,
    output logic [FPU_LANES-1:0]          fpu_lane_mask,
    output logic [PIDW-1:0]               fpu_tag,
    output logic [3:0]                    fpu_op_type,
    output logic [1:0]                    fpu_fmt,
    output logic [2:0]                    fpu_frm,
    output logic [FPU_LANES*DATAW-1:0]    fpu_dataa,
    output logic [FPU_LANES*DATAW-1:0]    fpu_datab,
    output logic [FPU_LANES*DATAW-1:0]    fpu_datac,
    input  logic                          fpu_rsp_valid,
    output logic                          fpu_rsp_ready,
    input  logic [FPU_LANES*DATAW-1:0]    fpu_rsp_result,
    input  logic                          fpu_rsp_has_fflags,
    input  logic [4:0]                    fpu_rsp_fflags,
    input  logic [PIDW-1:0]               fpu_rsp_tag
);
    localparam int CNTW = PIDW + 1;
    localparam int PKTW = FPU_LANES * DATAW;
    localparam int VECW = NUM_LANES * DATAW;

    if (NUM_LANES % FPU_LANES != 0) begin : g_bad_cfg
        $error("NUM_LANES must be a multiple of FPU_LANES");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;
    state_t r_state, w_state_nxt;

    logic [NUM_LANES-1:0] r_mask;
    logic [NUM_PKTS-1:0]  r_active, r_issued, w_new_active, w_pend;
    logic [CNTW-1:0]      r_npkts, r_iss_cnt, r_rcv_cnt, w_new_npkts, w_iss_nxt, w_rcv_nxt;
    logic [TAGW-1:0]      r_tag;
    logic [3:0]           r_op;
    logic [1:0]           r_fmt;
    logic [2:0]           r_frm;
    logic [VECW-1:0]      r_dataa, r_datab, r_datac, r_result;
    logic [4:0]           r_fflags;
    logic                 r_has_fflags;
    logic [PIDW-1:0]      w_pid;
    logic                 w_accept, w_issue_fire, w_rsp_fire;

    // Fire signals come straight from state so they do not loop back through the FSM outputs.
    assign w_accept     = (r_state == S_IDLE) & valid_in;
    assign w_issue_fire = (r_state == S_ISSUE) & fpu_ready;
    assign w_rsp_fire   = ((r_state == S_ISSUE) | (r_state == S_DRAIN)) & fpu_rsp_valid;
    assign w_iss_nxt    = r_iss_cnt + CNTW'(w_issue_fire);
    assign w_rcv_nxt    = r_rcv_cnt + CNTW'(w_rsp_fire);

    always_comb begin
        w_new_active = '0;
        w_new_npkts  = '0;
        for (int p = 0; p < NUM_PKTS; p++) begin
            w_new_active[p] = |lane_mask[p*FPU_LANES +: FPU_LANES];
            w_new_npkts     = w_new_npkts + CNTW'(w_new_active[p]);
        end
    end

    // Lowest-index active packet not yet issued; the descending scan lets the lowest win.
    always_comb begin
        w_pend = r_active & ~r_issued;
        w_pid  = '0;
        for (int p = NUM_PKTS - 1; p >= 0; p--) begin
            if (w_pend[p]) w_pid = PIDW'(p);
        end
    end

    always_comb begin
        fpu_lane_mask = '0;
        fpu_dataa     = '0;
        fpu_datab     = '0;
        fpu_datac     = '0;
        for (int p = 0; p < NUM_PKTS; p++) begin
            if (w_pid == PIDW'(p)) begin
                fpu_lane_mask = r_mask[p*FPU_LANES +: FPU_LANES];
                fpu_dataa     = r_dataa[p*PKTW +: PKTW];
                fpu_datab     = r_datab[p*PKTW +: PKTW];
                fpu_datac     = r_datac[p*PKTW +: PKTW];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        ready_in      = 1'b0;
        valid_out     = 1'b0;
        fpu_valid     = 1'b0;
        fpu_rsp_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_in = 1'b1;
                if (valid_in) w_state_nxt = (w_new_active == '0) ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                fpu_valid     = 1'b1;
                fpu_rsp_ready = 1'b1;
                if (w_issue_fire && (w_iss_nxt == r_npkts))
                    w_state_nxt = (w_rcv_nxt == r_npkts) ? S_RESP : S_DRAIN;
            end
            S_DRAIN: begin
                fpu_rsp_ready = 1'b1;
                if (w_rcv_nxt == r_npkts) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                valid_out = 1'b1;
                if (ready_out) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_active     <= '0;
            r_issued     <= '0;
            r_npkts      <= '0;
            r_iss_cnt    <= '0;
            r_rcv_cnt    <= '0;
            r_tag        <= '0;
            r_result     <= '0;
            r_fflags     <= '0;
            r_has_fflags <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mask       <= lane_mask;
                r_active     <= w_new_active;
                r_npkts      <= w_new_npkts;
                r_issued     <= '0;
                r_iss_cnt    <= '0;
                r_rcv_cnt    <= '0;
                r_tag        <= tag_in;
                r_result     <= '0;
                r_fflags     <= '0;
                r_has_fflags <= 1'b0;
            end
            if (w_issue_fire) begin
                r_iss_cnt <= w_iss_nxt;
                for (int p = 0; p < NUM_PKTS; p++) begin
                    if (w_pid == PIDW'(p)) r_issued[p] <= 1'b1;
                end
            end
            // Masked-off lanes keep the zero written at accept.
            if (w_rsp_fire) begin
                r_rcv_cnt <= w_rcv_nxt;
                if (fpu_rsp_has_fflags) begin
                    r_fflags     <= r_fflags | fpu_rsp_fflags;
                    r_has_fflags <= 1'b1;
                end
                for (int p = 0; p < NUM_PKTS; p++) begin
                    for (int l = 0; l < FPU_LANES; l++) begin
                        if ((fpu_rsp_tag == PIDW'(p)) && r_mask[p*FPU_LANES + l])
                            r_result[(p*FPU_LANES + l)*DATAW +: DATAW] <= fpu_rsp_result[l*DATAW +: DATAW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= op_type;
            r_fmt   <= fmt;
            r_frm   <= frm;
            r_dataa <= dataa;
            r_datab <= datab;
            r_datac <= datac;
        end
    end

    assign result      = r_result;
    assign fflags      = r_fflags;
    assign has_fflags  = r_has_fflags;
    assign tag_out     = r_tag;
    assign fpu_tag     = w_pid;
    assign fpu_op_type = r_op;
    assign fpu_fmt     = r_fmt;
    assign fpu_frm     = r_frm;

`ifndef SYNTHESIS
    a_rsp_only_when_ready: assert property (@(posedge clk) disable iff (reset)
        fpu_rsp_valid |-> fpu_rsp_ready);
`endif
endmodule

// File: tb/tb_fpu_lane_sequencer.sv
// Directed bench for fpu_lane_sequencer: vector table plus hand sequences for
// out-of-order responses, core and upstream backpressure, and reset while draining.
module tb_fpu_lane_sequencer;
    localparam int NL = 4, FL = 1, TW = 4, DW = 32, PW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, valid_in, ready_in, valid_out, ready_out;
    logic [NL-1:0]     lane_mask;
    logic [TW-1:0]     tag_in, tag_out;
    logic [3:0]        op_type, fpu_op_type;
    logic [1:0]        fmt, fpu_fmt;
    logic [2:0]        frm, fpu_frm;
    logic [NL*DW-1:0]  dataa, datab, datac, result;
    logic              has_fflags;
    logic [4:0]        fflags;
    logic              fpu_valid, fpu_ready;
    logic [FL-1:0]     fpu_lane_mask;
    logic [PW-1:0]     fpu_tag;
    logic [FL*DW-1:0]  fpu_dataa, fpu_datab, fpu_datac;
    logic              fpu_rsp_valid, fpu_rsp_ready, fpu_rsp_has_fflags;
    logic [FL*DW-1:0]  fpu_rsp_result;
    logic [4:0]        fpu_rsp_fflags;
    logic [PW-1:0]     fpu_rsp_tag;

    fpu_lane_sequencer #(.NUM_LANES(NL), .FPU_LANES(FL), .TAGW(TW), .DATAW(DW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .lane_mask(lane_mask), .tag_in(tag_in), .op_type(op_type), .fmt(fmt), .frm(frm),
        .dataa(dataa), .datab(datab), .datac(datac),
        .valid_out(valid_out), .ready_out(ready_out), .result(result),
        .has_fflags(has_fflags), .fflags(fflags), .tag_out(tag_out),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_lane_mask(fpu_lane_mask),
        .fpu_tag(fpu_tag), .fpu_op_type(fpu_op_type), .fpu_fmt(fpu_fmt), .fpu_frm(fpu_frm),
        .fpu_dataa(fpu_dataa), .fpu_datab(fpu_datab), .fpu_datac(fpu_datac),
        .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_ready(fpu_rsp_ready),
        .fpu_rsp_result(fpu_rsp_result), .fpu_rsp_has_fflags(fpu_rsp_has_fflags),
        .fpu_rsp_fflags(fpu_rsp_fflags), .fpu_rsp_tag(fpu_rsp_tag)
    );

    // Core model: fixed latency 2, result = a+b+c, flags looked up per packet index.
    logic        auto_core = 1'b1;
    logic [3:0]  has_cur = '0;
    logic [19:0] flg_cur = '0;
    logic        s1_v = 1'b0, s2_v = 1'b0, s1_h = 1'b0, s2_h = 1'b0;
    logic [PW-1:0] s1_t = '0, s2_t = '0;
    logic [31:0] s1_r = '0, s2_r = '0;
    logic [4:0]  s1_f = '0, s2_f = '0;
    logic        man_v = 1'b0, man_h = 1'b0;
    logic [PW-1:0] man_t = '0;
    logic [31:0] man_r = '0;
    logic [4:0]  man_f = '0;

    always @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= fpu_valid && fpu_ready;
            s1_t <= fpu_tag;
            s1_r <= fpu_dataa + fpu_datab + fpu_datac;
            s1_h <= has_cur[fpu_tag];
            s1_f <= flg_cur[int'(fpu_tag)*5 +: 5];
            s2_v <= s1_v; s2_t <= s1_t; s2_r <= s1_r; s2_h <= s1_h; s2_f <= s1_f;
        end
    end

    assign fpu_rsp_valid      = auto_core ? s2_v : man_v;
    assign fpu_rsp_tag        = auto_core ? s2_t : man_t;
    assign fpu_rsp_result     = auto_core ? s2_r : man_r;
    assign fpu_rsp_has_fflags = auto_core ? s2_h : man_h;
    assign fpu_rsp_fflags     = auto_core ? s2_f : man_f;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int iss_tag[$], iss_cyc[$];
    logic [31:0] ex_a[4], ex_lane[4];

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  tag;
        logic [31:0] seed;
        logic [3:0]  has;
        logic [19:0] flg;
        int          lat;
        logic [4:0]  ef;
        logic        eh;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        if (fpu_valid === 1'b1 && fpu_ready === 1'b1) begin
            iss_tag.push_back(int'(fpu_tag));
            iss_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] s);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b, c;
            a = s + 32'h0101_0101 * 32'(i);
            b = {s[15:0], s[31:16]} ^ (32'h11 << i);
            c = 32'h100 + 32'h7 * 32'(i);
            dataa[i*32 +: 32] = a;
            datab[i*32 +: 32] = b;
            datac[i*32 +: 32] = c;
            ex_a[i]    = a;
            ex_lane[i] = a + b + c;
        end
    endtask

    function automatic logic [127:0] exp_result(input logic [3:0] m);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*32 +: 32] = ex_lane[i];
        return r;
    endfunction

    task automatic send_req(input logic [3:0] m, input logic [3:0] t, input logic [31:0] seed);
        set_ops(seed);
        iss_tag.delete();
        iss_cyc.delete();
        valid_in  = 1'b1;
        lane_mask = m;
        tag_in    = t;
        op_type   = t ^ 4'hA;
        fmt       = t[1:0];
        frm       = t[3:1];
        step();
        valid_in  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int exp_tags[$];
        int t0, k;
        auto_core = 1'b1;
        has_cur   = v.has;
        flg_cur   = v.flg;
        for (int p = 0; p < 4; p++) if (v.mask[p]) exp_tags.push_back(p);
        t0 = cyc;
        send_req(v.mask, v.tag, v.seed);
        k = 1;
        while (valid_out !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk({nm, ".lat"}, k, v.lat);
        chk({nm, ".n_iss"}, iss_tag.size(), exp_tags.size());
        foreach (exp_tags[j]) begin
            chk({nm, ".iss_tag"}, (j < iss_tag.size()) ? iss_tag[j] : -1, exp_tags[j]);
            chk({nm, ".iss_cyc"}, (j < iss_cyc.size()) ? iss_cyc[j] - t0 : -1, j + 1);
        end
        chk({nm, ".result"}, result, exp_result(v.mask));
        chk({nm, ".fflags"}, fflags, v.ef);
        chk({nm, ".has_fflags"}, has_fflags, v.eh);
        chk({nm, ".tag_out"}, tag_out, v.tag);
        chk({nm, ".passthru"}, {fpu_op_type, fpu_fmt, fpu_frm}, {v.tag ^ 4'hA, v.tag[1:0], v.tag[3:1]});
        step();
        chk({nm, ".idle"}, {ready_in, valid_out}, 2'b10);
    endtask

    task automatic send_rsp(input logic [1:0] t, input logic h, input logic [4:0] f, input logic [31:0] r);
        man_v = 1'b1; man_t = t; man_h = h; man_f = f; man_r = r;
        step();
        man_v = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{4'hF, 4'h3, 32'h1000_0000, 4'b0000, 20'h00000, 7, 5'h00, 1'b0};
        vecs[1] = '{4'h5, 4'h9, 32'h2345_6789, 4'b0101, 20'h02002, 5, 5'h0A, 1'b1};
        vecs[2] = '{4'h0, 4'h5, 32'hDEAD_BEEF, 4'b1111, 20'hFFFFF, 1, 5'h00, 1'b0};
        vecs[3] = '{4'h8, 4'hA, 32'h0F0F_0F0F, 4'b1000, 20'h88000, 4, 5'h11, 1'b1};
        vecs[4] = '{4'h6, 4'hC, 32'h7FFF_FFFF, 4'b0010, 20'h04080, 5, 5'h04, 1'b1};

        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1; fpu_ready = 1'b1;
        lane_mask = '0; tag_in = '0; op_type = '0; fmt = '0; frm = '0;
        dataa = '0; datab = '0; datac = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst.ready_in", ready_in, 1'b1);
        chk("rst.valid_out", valid_out, 1'b0);
        chk("rst.fpu_valid", fpu_valid, 1'b0);
        chk("rst.fpu_rsp_ready", fpu_rsp_ready, 1'b0);
        chk("rst.outs", {result, fflags, has_fflags, tag_out}, '0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Out-of-order responses with hand-picked results and flags
        auto_core = 1'b0;
        send_req(4'hF, 4'h7, 32'h3141_5926);
        repeat (4) step();
        chk("ooo.n_iss", iss_tag.size(), 4);
        chk("ooo.drain", {fpu_valid, fpu_rsp_ready, valid_out}, 3'b010);
        send_rsp(2'd3, 1'b1, 5'h04, 32'hA3A3_0003);
        send_rsp(2'd0, 1'b1, 5'h01, 32'hA0A0_0000);
        send_rsp(2'd1, 1'b0, 5'h10, 32'hA1A1_0001);
        chk("ooo.not_done", valid_out, 1'b0);
        send_rsp(2'd2, 1'b0, 5'h00, 32'hA2A2_0002);
        chk("ooo.valid_out", valid_out, 1'b1);
        chk("ooo.result", result, {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000});
        chk("ooo.fflags", fflags, 5'h05);
        chk("ooo.has_fflags", has_fflags, 1'b1);
        chk("ooo.tag_out", tag_out, 4'h7);
        step();
        auto_core = 1'b1;

        // Core stalls for 3 cycles while packet 1 is presented
        has_cur = '0; flg_cur = '0;
        send_req(4'hF, 4'h2, 32'h5555_AAAA);
        chk("bp.p0_tag", fpu_tag, 2'd0);
        step();
        fpu_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("bp.hold_valid", fpu_valid, 1'b1);
            chk("bp.hold_tag", fpu_tag, 2'd1);
            chk("bp.hold_mask", fpu_lane_mask, 1'b1);
            chk("bp.hold_data", fpu_dataa, ex_a[1]);
            step();
        end
        fpu_ready = 1'b1;
        k = 0;
        while (valid_out !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("bp.done", valid_out, 1'b1);
        chk("bp.n_iss", iss_tag.size(), 4);
        for (int j = 0; j < 4; j++) chk("bp.iss_order", (j < iss_tag.size()) ? iss_tag[j] : -1, j);
        chk("bp.result", result, exp_result(4'hF));
        step();

        // Upstream stalls the response for 5 cycles
        ready_out = 1'b0;
        send_req(4'h3, 4'h4, 32'h0BAD_F00D);
        k = 0;
        while (valid_out !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        for (int j = 0; j < 5; j++) begin
            chk("ro.valid_out", valid_out, 1'b1);
            chk("ro.ready_in", ready_in, 1'b0);
            chk("ro.result", result, exp_result(4'h3));
            chk("ro.tag_out", tag_out, 4'h4);
            step();
        end
        ready_out = 1'b1;
        step();
        chk("ro.release", {valid_out, ready_in}, 2'b01);

        // Reset while waiting for responses, then a fresh request
        send_req(4'hF, 4'h1, 32'h1234_5678);
        repeat (4) step();
        chk("rd.in_drain", {fpu_valid, fpu_rsp_ready, valid_out}, 3'b010);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rd.ready_in", ready_in, 1'b1);
        chk("rd.valid_out", valid_out, 1'b0);
        chk("rd.fpu_rsp_ready", fpu_rsp_ready, 1'b0);
        step();
        chk("rd.quiet", {valid_out, fpu_valid}, 2'b00);
        run_vec(vecs[1], "rd.next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
